// File: rtl/mul_share_arbiter.sv
// Shared signed multiplier with round-robin arbitration across requesters.
// A single Baugh-Wooley array serves all requesters; the granted operands are
// multiplied combinationally and captured in a one-entry output register.
// Optional feature: define MUL_SHARE_STALL_CNT_EN to add the 16-bit
// saturating output-stall counter (stall_cnt_o).
`timescale 1ns/1ps

// Combinational Baugh-Wooley signed multiplier (two's complement operands).
module baugh_wooley #(
  parameter int p_width = 8
) (
  input  logic [p_width-1:0]   a_i,
  input  logic [p_width-1:0]   b_i,
  output logic [2*p_width-1:0] product_o
);

  // Sign-row/column partial products are inverted and the two constant
  // correction bits (2^n and 2^(2n-1)) are added, giving the exact product
  // modulo 2^(2n) without any sign extension of the partial products.
  always_comb begin
    logic [2*p_width-1:0] acc;
    logic [2*p_width-1:0] term;
    logic                 pp;
    logic                 a_msb;
    logic                 b_msb;
    acc = '0;
    for (int unsigned i = 0; i < p_width; i++) begin
      for (int unsigned j = 0; j < p_width; j++) begin
        a_msb = (i == p_width - 1);
        b_msb = (j == p_width - 1);
        pp    = a_i[i] & b_i[j];
        if (a_msb ^ b_msb) begin
          pp = ~pp;
        end
        term = '0;
        term[0] = pp;
        acc = acc + (term << (i + j));
      end
    end
    term = '0;
    term[p_width] = 1'b1;
    term[2*p_width-1] = 1'b1;
    product_o = acc + term;
  end

endmodule

module mul_share_arbiter #(
  parameter  int p_width    = 8,
  parameter  int p_num_req  = 4,
  localparam int p_id_width = $clog2(p_num_req)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [p_num_req-1:0]              req_valid_i,
  output logic [p_num_req-1:0]              req_ready_o,
  input  logic [p_num_req-1:0][p_width-1:0] req_a_i,
  input  logic [p_num_req-1:0][p_width-1:0] req_b_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [p_id_width-1:0]             rsp_id_o,
  output logic [2*p_width-1:0]              rsp_product_o
`ifdef MUL_SHARE_STALL_CNT_EN
  ,
  output logic [15:0]                       stall_cnt_o
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [p_id_width-1:0]   last_grant_q, last_grant_d;
  logic [p_id_width-1:0]   rsp_id_q, rsp_id_d;
  logic [2*p_width-1:0]    rsp_product_q, rsp_product_d;

  logic                    slot_free;
  logic                    any_valid;
  logic                    grant_en;
  logic [p_id_width-1:0]   grant_idx;
  logic [p_width-1:0]      mul_a;
  logic [p_width-1:0]      mul_b;
  logic [2*p_width-1:0]    mul_product;

  // Round-robin search starting one past the last transferred requester.
  always_comb begin
    logic                  found;
    logic [p_id_width-1:0] cand;
    found     = 1'b0;
    cand      = '0;
    grant_idx = last_grant_q;
    for (int unsigned k = 1; k <= p_num_req; k++) begin
      cand = p_id_width'((32'(last_grant_q) + k) % p_num_req);
      if (!found && req_valid_i[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign any_valid = |req_valid_i;
  assign slot_free = (state_q == EMPTY) || rsp_ready_i;
  assign grant_en  = rst_ni && slot_free && any_valid;

  // Operand mux from the granted requester into the shared multiplier.
  always_comb begin
    mul_a = req_a_i[grant_idx];
    mul_b = req_b_i[grant_idx];
  end

  baugh_wooley #(
    .p_width (p_width)
  ) u_mul (
    .a_i       (mul_a),
    .b_i       (mul_b),
    .product_o (mul_product)
  );

  // One-hot accept for the granted requester, only in the grant cycle.
  always_comb begin
    req_ready_o = '0;
    if (grant_en) begin
      req_ready_o[grant_idx] = 1'b1;
    end
  end

  // Next-state: FULL persists while stalled, refills on grant, else drains.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    rsp_id_d      = rsp_id_q;
    rsp_product_d = rsp_product_q;
    if (grant_en) begin
      state_d       = FULL;
      last_grant_d  = grant_idx;
      rsp_id_d      = grant_idx;
      rsp_product_d = mul_product;
    end else if (slot_free) begin
      state_d = EMPTY;
    end
  end

  // State, pointer and output register; reset discards any pending result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= EMPTY;
      last_grant_q  <= p_id_width'(p_num_req - 1);
      rsp_id_q      <= '0;
      rsp_product_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      rsp_id_q      <= rsp_id_d;
      rsp_product_q <= rsp_product_d;
    end
  end

  assign rsp_valid_o   = (state_q == FULL);
  assign rsp_id_o      = rsp_id_q;
  assign rsp_product_o = rsp_product_q;

`ifdef MUL_SHARE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles where a held result is not accepted.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == FULL) && !rsp_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter (p_width=8, p_num_req=4).
`timescale 1ns/1ps

module tb_mul_share_arbiter;

  logic             clk_i;
  logic             rst_ni;
  logic [3:0]       req_valid_i;
  logic [3:0]       req_ready_o;
  logic [3:0][7:0]  req_a_i;
  logic [3:0][7:0]  req_b_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [1:0]       rsp_id_o;
  logic [15:0]      rsp_product_o;
`ifdef MUL_SHARE_STALL_CNT_EN
  logic [15:0]      stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  mul_share_arbiter #(
    .p_width   (8),
    .p_num_req (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_id_o      (rsp_id_o),
    .rsp_product_o (rsp_product_o)
`ifdef MUL_SHARE_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_ni      = 1'b0;
    req_valid_i = 4'b1111;
    rsp_ready_i = 1'b1;
    req_a_i     = '0;
    req_b_i     = '0;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready_comb got=%b exp=%b", req_ready_o, 4'b0000);
    end
    step();
    step();
    n_tests++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid_o);
    end
    n_tests++;
    if (rsp_product_o !== 16'h0000) begin
      n_fail++; $display("FAIL reset_product got=%h exp=0000", rsp_product_o);
    end
    n_tests++;
    if (rsp_id_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_id got=%0d exp=0", rsp_id_o);
    end
    n_tests++;
    if (req_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o);
    end
    rst_ni      = 1'b1;
    req_valid_i = '0;
    #1;
  endtask

  task automatic test_single;
    do_reset();
    req_a_i[0]  = 8'd3;
    req_b_i[0]  = 8'hFB;   // -5
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b1;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0001) begin
      n_fail++; $display("FAIL single_ready got=%b exp=0001", req_ready_o);
    end
    n_tests++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_no_early_valid got=%b exp=0", rsp_valid_o);
    end
    step();
    req_valid_i = '0;
    #1;
    n_tests++;
    if (rsp_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL single_valid got=%b exp=1", rsp_valid_o);
    end
    n_tests++;
    if (rsp_id_o !== 2'd0) begin
      n_fail++; $display("FAIL single_id got=%0d exp=0", rsp_id_o);
    end
    n_tests++;
    if (rsp_product_o !== 16'hFFF1) begin
      n_fail++; $display("FAIL single_product got=%h exp=fff1", rsp_product_o);
    end
    step();
    n_tests++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL single_drain got=%b exp=0", rsp_valid_o);
    end
  endtask

  task automatic test_fairness;
    logic [15:0] exp_prod;
    logic [3:0]  exp_ready;
    logic [1:0]  g;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      req_a_i[k] = 8'(k + 1);
      req_b_i[k] = 8'd3;
    end
    req_valid_i = 4'b1111;
    rsp_ready_i = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      g         = 2'(c % 4);
      exp_ready = 4'b0001 << g;
      exp_prod  = 16'(3 * ((c % 4) + 1));
      n_tests++;
      if (req_ready_o !== exp_ready) begin
        n_fail++; $display("FAIL fair_ready c=%0d got=%b exp=%b", c, req_ready_o, exp_ready);
      end
      step();
      n_tests++;
      if (rsp_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL fair_valid c=%0d got=%b exp=1", c, rsp_valid_o);
      end
      n_tests++;
      if (rsp_id_o !== g) begin
        n_fail++; $display("FAIL fair_id c=%0d got=%0d exp=%0d", c, rsp_id_o, g);
      end
      n_tests++;
      if (rsp_product_o !== exp_prod) begin
        n_fail++; $display("FAIL fair_product c=%0d got=%h exp=%h", c, rsp_product_o, exp_prod);
      end
    end
    req_valid_i = '0;
    step();
    n_tests++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL fair_drain got=%b exp=0", rsp_valid_o);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    req_a_i[0]  = 8'd3;
    req_b_i[0]  = 8'hFB;   // -5
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0001) begin
      n_fail++; $display("FAIL bp_first_ready got=%b exp=0001", req_ready_o);
    end
    step();
    req_a_i[2]  = 8'hF9;   // -7
    req_b_i[2]  = 8'd6;
    req_valid_i = 4'b0100;
    #1;
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (req_ready_o !== 4'b0000) begin
        n_fail++; $display("FAIL bp_hold_ready c=%0d got=%b exp=0000", c, req_ready_o);
      end
      n_tests++;
      if (rsp_valid_o !== 1'b1 || rsp_product_o !== 16'hFFF1 || rsp_id_o !== 2'd0) begin
        n_fail++; $display("FAIL bp_hold_output c=%0d got=%b/%h/%0d exp=1/fff1/0",
                           c, rsp_valid_o, rsp_product_o, rsp_id_o);
      end
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready_o);
    end
    step();
    req_valid_i = '0;
    #1;
    n_tests++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2 || rsp_product_o !== 16'hFFD6) begin
      n_fail++; $display("FAIL bp_refill got=%b/%0d/%h exp=1/2/ffd6",
                         rsp_valid_o, rsp_id_o, rsp_product_o);
    end
    step();
    n_tests++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_drain got=%b exp=0", rsp_valid_o);
    end
  endtask

  task automatic test_corners;
    logic [7:0]  ca [6];
    logic [7:0]  cb [6];
    logic [15:0] cp [6];
    ca = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01};
    cb = '{8'h80, 8'h7F, 8'h7F, 8'hFF, 8'h80, 8'h80};
    cp = '{16'h4000, 16'hC080, 16'h3F01, 16'h0001, 16'h0000, 16'hFF80};
    do_reset();
    rsp_ready_i = 1'b1;
    req_valid_i = 4'b0001;
    for (int v = 0; v < 6; v++) begin
      req_a_i[0] = ca[v];
      req_b_i[0] = cb[v];
      #1;
      step();
      n_tests++;
      if (rsp_valid_o !== 1'b1 || rsp_product_o !== cp[v]) begin
        n_fail++; $display("FAIL corner v=%0d a=%h b=%h got=%b/%h exp=1/%h",
                           v, ca[v], cb[v], rsp_valid_o, rsp_product_o, cp[v]);
      end
    end
    req_valid_i = '0;
    step();
  endtask

  task automatic test_reset_mid;
    do_reset();
    req_a_i[3]  = 8'd5;
    req_b_i[3]  = 8'd5;
    req_valid_i = 4'b1000;
    rsp_ready_i = 1'b0;
    #1;
    step();
    req_valid_i = '0;
    #1;
    n_tests++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd3 || rsp_product_o !== 16'd25) begin
      n_fail++; $display("FAIL mid_full got=%b/%0d/%h exp=1/3/0019",
                         rsp_valid_o, rsp_id_o, rsp_product_o);
    end
    rst_ni      = 1'b0;
    rsp_ready_i = 1'b1;
    req_valid_i = 4'b1111;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL mid_ready_in_reset got=%b exp=0000", req_ready_o);
    end
    step();
    n_tests++;
    if (rsp_valid_o !== 1'b0 || rsp_product_o !== 16'h0000 || rsp_id_o !== 2'd0) begin
      n_fail++; $display("FAIL mid_cleared got=%b/%h/%0d exp=0/0000/0",
                         rsp_valid_o, rsp_product_o, rsp_id_o);
    end
    rst_ni = 1'b1;
    #1;
    n_tests++;
    if (req_ready_o !== 4'b0001) begin
      n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready_o);
    end
    step();
    req_valid_i = '0;
    #1;
    n_tests++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0) begin
      n_fail++; $display("FAIL mid_first_rsp got=%b/%0d exp=1/0", rsp_valid_o, rsp_id_o);
    end
    step();
  endtask

`ifdef MUL_SHARE_STALL_CNT_EN
  task automatic test_stall_cnt;
    do_reset();
    n_tests++;
    if (stall_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL stall_reset got=%0d exp=0", stall_cnt_o);
    end
    req_a_i[0]  = 8'd2;
    req_b_i[0]  = 8'd2;
    req_valid_i = 4'b0001;
    rsp_ready_i = 1'b0;
    #1;
    step();
    req_valid_i = '0;
    #1;
    n_tests++;
    if (stall_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL stall_at_fill got=%0d exp=0", stall_cnt_o);
    end
    repeat (7) step();
    n_tests++;
    if (stall_cnt_o !== 16'd7) begin
      n_fail++; $display("FAIL stall_7 got=%0d exp=7", stall_cnt_o);
    end
    repeat (70000) step();
    n_tests++;
    if (stall_cnt_o !== 16'hFFFF) begin
      n_fail++; $display("FAIL stall_saturate got=%h exp=ffff", stall_cnt_o);
    end
    rsp_ready_i = 1'b1;
    step();
    n_tests++;
    if (stall_cnt_o !== 16'hFFFF || rsp_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold got=%h/%b exp=ffff/0", stall_cnt_o, rsp_valid_o);
    end
    do_reset();
    n_tests++;
    if (stall_cnt_o !== 16'd0) begin
      n_fail++; $display("FAIL stall_cleared got=%0d exp=0", stall_cnt_o);
    end
  endtask
`endif

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    req_a_i     = '0;
    req_b_i     = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_corners();
    test_reset_mid();
`ifdef MUL_SHARE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
